// File: rtl/demux_1to12_scatter_pkg.sv
// demux_1to12_scatter_pkg: shared widths, lane count and FSM state type for the 1:12 scatter
package demux_1to12_scatter_pkg;
    localparam int DATA_W    = 16;
    localparam int NUM_LANES = 12;
    localparam int SEL_W     = 4;
    typedef enum logic {FILL, HOLD} scatter_state_t;
endpackage

// File: rtl/demux_1to12_scatter_if.sv
// demux_1to12_scatter_if: word stream in, lane bank out
//   in_data/in_valid/in_last/in_ready : upstream word handshake
//   out_data/out_lane_valid/out_valid/out_ready : downstream bank handshake
//   lane_ptr : next lane to be written
interface demux_1to12_scatter_if;
    import demux_1to12_scatter_pkg::*;
    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [NUM_LANES*DATA_W-1:0] out_data;
    logic [NUM_LANES-1:0]        out_lane_valid;
    logic                        out_valid;
    logic                        out_ready;
    logic [SEL_W-1:0]            lane_ptr;
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_lane_valid, out_valid, lane_ptr
    );
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_lane_valid, out_valid, lane_ptr
    );
endinterface

// File: rtl/demux_1to12_scatter.sv
// demux_1to12_scatter: scatters a word stream into 12 lanes and hands the bank off in parallel
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave view of demux_1to12_scatter_if
module demux_1to12_scatter
    import demux_1to12_scatter_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    demux_1to12_scatter_if.slave bus
);
    scatter_state_t       r_state;
    scatter_state_t       w_state_nxt;
    logic [DATA_W-1:0]    r_lane [NUM_LANES];
    logic [NUM_LANES-1:0] r_lane_valid;
    logic [SEL_W-1:0]     r_ptr;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_release;
    logic                 w_in_ready;
    logic                 w_out_valid;
    always_comb begin
        w_in_ready  = r_state == FILL;
        w_out_valid = r_state == HOLD;
        w_accept    = w_in_ready && bus.in_valid;
        // frame ends on the explicit last word or when the final lane is filled
        w_done      = w_accept && (bus.in_last || r_ptr == SEL_W'(NUM_LANES - 1));
        w_release   = w_out_valid && bus.out_ready;
        w_state_nxt = w_done ? HOLD : w_release ? FILL : r_state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= FILL;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= '0;
            r_lane_valid <= '0;
            r_ptr        <= '0;
        end else if (w_release) begin
            // unwritten lanes must read as zero in the next frame
            for (int i = 0; i < NUM_LANES; i++) r_lane[i] <= '0;
            r_lane_valid <= '0;
            r_ptr        <= '0;
        end else if (w_accept) begin
            r_lane[r_ptr]       <= bus.in_data;
            r_lane_valid[r_ptr] <= 1'b1;
            r_ptr               <= r_ptr + SEL_W'(1);
        end
    end
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
        assign bus.out_data[g*DATA_W +: DATA_W] = r_lane[g];
    end
    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_lane_valid = r_lane_valid;
    assign bus.lane_ptr       = r_ptr;
endmodule

// File: tb/tb_demux_1to12_scatter.sv
// tb_demux_1to12_scatter: randomized and directed checks of the scatter against a frame-level model
module tb_demux_1to12_scatter;
    import demux_1to12_scatter_pkg::*;
    localparam int BW = NUM_LANES * DATA_W;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    demux_1to12_scatter_if bus();
    demux_1to12_scatter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int n_tests = 0;
    int n_fail = 0;
    int n_bubble = 0;
    logic [DATA_W-1:0] m_lane [NUM_LANES];
    int m_n = 0;
    bit m_hold = 1'b0;
    task automatic check(string tag, logic [BW-1:0] got, logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic m_clear();
        for (int i = 0; i < NUM_LANES; i++) m_lane[i] = '0;
        m_n = 0;
        m_hold = 1'b0;
    endtask
    function automatic logic [BW-1:0] m_bank();
        logic [BW-1:0] b = '0;
        for (int i = 0; i < NUM_LANES; i++) b[i*DATA_W +: DATA_W] = m_lane[i];
        return b;
    endfunction
    function automatic logic [NUM_LANES-1:0] m_lv();
        logic [NUM_LANES-1:0] v = '0;
        for (int i = 0; i < m_n; i++) v[i] = 1'b1;
        return v;
    endfunction
    task automatic check_all(string tag);
        check({tag, ".in_ready"}, BW'(bus.in_ready), BW'(!m_hold));
        check({tag, ".out_valid"}, BW'(bus.out_valid), BW'(m_hold));
        check({tag, ".lane_ptr"}, BW'(bus.lane_ptr), BW'(m_n));
        check({tag, ".lane_valid"}, BW'(bus.out_lane_valid), BW'(m_lv()));
        check({tag, ".out_data"}, bus.out_data, m_bank());
    endtask
    task automatic step(string tag, bit v, logic [DATA_W-1:0] d, bit l, bit o);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = o;
        if (!bus.in_ready) n_bubble++;
        @(posedge clk);
        if (!m_hold) begin
            if (v) begin
                m_lane[m_n] = d;
                m_n++;
                if (l || m_n == NUM_LANES) m_hold = 1'b1;
            end
        end else if (o) begin
            m_clear();
        end
        #1 check_all(tag);
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        m_clear();
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) reset_n = 1'b1;
        #1 check("reset.release_ready", BW'(bus.in_ready), BW'(1));
        for (int i = 0; i < NUM_LANES; i++) step("full", 1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
        check("full.lane_valid_fff", BW'(bus.out_lane_valid), BW'(12'hFFF));
        check("full.lane11", BW'(bus.out_data[11*DATA_W +: DATA_W]), BW'(16'h010B));
        for (int i = 0; i < 20; i++) step("bp", 1'b1, DATA_W'($urandom), 1'(i[0]), 1'b0);
        step("bp_release", 1'b0, '0, 1'b0, 1'b1);
        check("bp.cleared_data", bus.out_data, '0);
        for (int i = 0; i < 5; i++) begin
            step("short", 1'b1, DATA_W'(16'hA000 + i), i == 4, 1'b0);
            if (i < 4) step("short_gap", 1'b0, DATA_W'($urandom), 1'b1, 1'b1);
        end
        check("short.lane_ptr5", BW'(bus.lane_ptr), BW'(5));
        check("short.lane_valid_1f", BW'(bus.out_lane_valid), BW'(12'h01F));
        check("short.lane4", BW'(bus.out_data[4*DATA_W +: DATA_W]), BW'(16'hA004));
        step("short_release", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step("partial", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        #2;
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        m_clear();
        #1 check_all("async_rst");
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) step("post_rst", 1'b1, DATA_W'(16'h5500 + i), 1'b0, 1'b0);
        check("post_rst.lane0", BW'(bus.out_data[DATA_W-1:0]), BW'(16'h5500));
        step("post_rst_release", 1'b0, '0, 1'b0, 1'b1);
        n_bubble = 0;
        for (int i = 0; i < 2 * (NUM_LANES + 1); i++) step("b2b", 1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        check("b2b.bubbles", BW'(n_bubble), BW'(2));
        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 9) < 7, DATA_W'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
